// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg.sv - shared state type, default sizes and width helper for the TDM receive link.
// Build option: define TDM_DEMUX_PARITY_EN to append one even-parity bit to every slot.
package tdm_pkg;

  typedef enum logic {IDLE, LOCKED} tdm_state_t;

  localparam int DEFAULT_NUM_CH = 4;
  localparam int DEFAULT_DATA_W = 8;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Bits needed to index n items (0..n-1); never less than one bit.
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if.sv - serial link inputs and per-channel outputs of the TDM demultiplexer.
// Build option: TDM_DEMUX_PARITY_EN adds the parity_err pulse to the bundle.
interface tdm_demux_if import tdm_pkg::*; #(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic                       din;
  logic                       din_en;
  logic                       frame_sync;
  logic [NUM_CH*DATA_W-1:0]   ch_data;
  logic [NUM_CH-1:0]          ch_valid;
  logic [cntWidth(NUM_CH)-1:0] ch_sel;
  logic                       locked;
  logic                       sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic                       parity_err;
`endif

`ifdef TDM_DEMUX_PARITY_EN
  modport master (
    output din, din_en, frame_sync,
    input  ch_data, ch_valid, ch_sel, locked, sync_err, parity_err
  );

  modport slave (
    input  din, din_en, frame_sync,
    output ch_data, ch_valid, ch_sel, locked, sync_err, parity_err
  );
`else
  modport master (
    output din, din_en, frame_sync,
    input  ch_data, ch_valid, ch_sel, locked, sync_err
  );

  modport slave (
    input  din, din_en, frame_sync,
    output ch_data, ch_valid, ch_sel, locked, sync_err
  );
`endif

endinterface

// File: rtl/tdm_demux_sipo_shift.sv
// tdm_demux_sipo_shift.sv - serial-in parallel-out shift register used to collect slot bits.
// Clear wins over shift; a clear with enable seeds bit 0 with the incoming bit so a new
// slot can start on the same edge that discards the old one.
module sipo_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         din_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] shift_q;
  logic [W-1:0] shift_d;
  logic [W-1:0] shifted;

  if (W == 1) begin : g_single
    assign shifted = din_i;
  end else begin : g_multi
    assign shifted = {shift_q[W-2:0], din_i};
  end

  // Next contents: clear (optionally seeded), shift MSB-first, or hold.
  always_comb begin
    shift_d = shift_q;
    if (clr_i) begin
      shift_d = '0;
      if (en_i) begin
        shift_d[0] = din_i;
      end
    end else if (en_i) begin
      shift_d = shifted;
    end
  end

  // Shift register storage.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign q_o = shift_q;

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux.sv - receive end of the shared-line TDM link. Locks onto frame_sync, collects
// each slot serially and steers it into that channel's output register.
// Build option: TDM_DEMUX_PARITY_EN adds a trailing even-parity bit per slot; slots that
// fail parity are dropped and flagged on parity_err without losing lock.
module tdm_demux import tdm_pkg::*; #(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input logic        clk,
  input logic        resetn,
  tdm_demux_if.slave bus
);

  localparam int SLOT_W = DATA_W + PARITY_BITS;
  localparam int SEL_W  = cntWidth(NUM_CH);
  localparam int CNT_W  = cntWidth(SLOT_W);
  // The last bit of a slot is taken straight off the line, so only SLOT_W-1 bits are stored.
  localparam int HELD_W = SLOT_W - 1;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_W - 1);

  tdm_state_t               state_q, state_d;
  logic [SEL_W-1:0]         chSel_q, chSel_d;
  logic [CNT_W-1:0]         bitCnt_q, bitCnt_d;
  logic [NUM_CH*DATA_W-1:0] chData_q, chData_d;
  logic [NUM_CH-1:0]        chValid_q, chValid_d;
  logic                     syncErr_q, syncErr_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic                     parityErr_q, parityErr_d;
  logic                     slotParityOk;
`endif

  logic                     shiftClr;
  logic                     shiftEn;
  logic [HELD_W-1:0]        heldBits;
  logic [SLOT_W-1:0]        slotBits;
  logic [DATA_W-1:0]        slotData;
  logic                     frameStart;

  sipo_shift #(.W(HELD_W)) u_sipo (
    .clk   (clk),
    .clr_i (shiftClr),
    .en_i  (shiftEn),
    .din_i (bus.din),
    .q_o   (heldBits)
  );

  assign slotBits   = {heldBits, bus.din};
  assign slotData   = slotBits[SLOT_W-1 -: DATA_W];
  assign frameStart = (chSel_q == '0) && (bitCnt_q == '0);
`ifdef TDM_DEMUX_PARITY_EN
  assign slotParityOk = ~(^slotBits);
`endif

  // Framing FSM, slot counters and channel steering; pulses default low every cycle.
  always_comb begin
    state_d   = state_q;
    chSel_d   = chSel_q;
    bitCnt_d  = bitCnt_q;
    chData_d  = chData_q;
    chValid_d = '0;
    syncErr_d = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    parityErr_d = 1'b0;
`endif
    shiftClr  = 1'b0;
    shiftEn   = 1'b0;

    if (!resetn) begin
      shiftClr = 1'b1;
    end else if (bus.din_en) begin
      case (state_q)
        IDLE: begin
          if (bus.frame_sync) begin
            state_d  = LOCKED;
            chSel_d  = '0;
            bitCnt_d = CNT_W'(1);
            shiftClr = 1'b1;
            shiftEn  = 1'b1;
          end
        end

        LOCKED: begin
          if (frameStart && !bus.frame_sync) begin
            // Frame should have restarted here; drop lock and ignore the bit.
            syncErr_d = 1'b1;
            state_d   = IDLE;
          end else if (!frameStart && bus.frame_sync) begin
            // Sync arrived early: abandon the partial slot and restart at ch0 bit 0.
            syncErr_d = 1'b1;
            chSel_d   = '0;
            bitCnt_d  = CNT_W'(1);
            shiftClr  = 1'b1;
            shiftEn   = 1'b1;
          end else begin
            shiftEn = 1'b1;
            if (bitCnt_q == LAST_BIT) begin
              bitCnt_d = '0;
              chSel_d  = (chSel_q == LAST_CH) ? '0 : chSel_q + 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
              if (slotParityOk) begin
                chData_d[chSel_q*DATA_W +: DATA_W] = slotData;
                chValid_d[chSel_q]                 = 1'b1;
              end else begin
                parityErr_d = 1'b1;
              end
`else
              chData_d[chSel_q*DATA_W +: DATA_W] = slotData;
              chValid_d[chSel_q]                 = 1'b1;
`endif
            end else begin
              bitCnt_d = bitCnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      chSel_q   <= '0;
      bitCnt_q  <= '0;
      chData_q  <= '0;
      chValid_q <= '0;
      syncErr_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parityErr_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      chSel_q   <= chSel_d;
      bitCnt_q  <= bitCnt_d;
      chData_q  <= chData_d;
      chValid_q <= chValid_d;
      syncErr_q <= syncErr_d;
`ifdef TDM_DEMUX_PARITY_EN
      parityErr_q <= parityErr_d;
`endif
    end
  end

  assign bus.ch_data  = chData_q;
  assign bus.ch_valid = chValid_q;
  assign bus.ch_sel   = chSel_q;
  assign bus.locked   = (state_q == LOCKED);
  assign bus.sync_err = syncErr_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.parity_err = parityErr_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux.sv - directed and randomized checks of tdm_demux (NUM_CH=4, DATA_W=8).
// Build option: TDM_DEMUX_PARITY_EN also exercises the parity bit and parity_err.
module tb_tdm_demux;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int SLOT_W = DATA_W + 1;
`else
  localparam int SLOT_W = DATA_W;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [DATA_W-1:0] expData [NUM_CH];
  logic expLocked = 1'b0;

  always #5 clk = ~clk;

  tdm_demux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  tdm_demux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Expected channel word assembled from the per-channel model.
  function automatic logic [NUM_CH*DATA_W-1:0] expWord();
    logic [NUM_CH*DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < NUM_CH; k++) w[k*DATA_W +: DATA_W] = expData[k];
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [NUM_CH-1:0] expValid, input int expSel,
                          input logic expLock, input logic expSyncErr);
    checkOutput({tag, "/ch_valid"}, 64'(bus.ch_valid), 64'(expValid));
    checkOutput({tag, "/ch_sel"}, 64'(bus.ch_sel), 64'(expSel));
    checkOutput({tag, "/locked"}, 64'(bus.locked), 64'(expLock));
    checkOutput({tag, "/sync_err"}, 64'(bus.sync_err), 64'(expSyncErr));
    checkOutput({tag, "/ch_data"}, 64'(bus.ch_data), 64'(expWord()));
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic checkParity(input string tag, input logic expErr);
    checkOutput({tag, "/parity_err"}, 64'(bus.parity_err), 64'(expErr));
  endtask
`endif

  // One clock: drive on the falling edge, return 1 time unit after the rising edge.
  task automatic applyStimulus(input logic d, input logic fs, input logic en, input logic rn);
    @(negedge clk);
    bus.din        = d;
    bus.frame_sync = fs;
    bus.din_en     = en;
    resetn         = rn;
    @(posedge clk);
    #1;
  endtask

  // Idle strobe cycles with random line content; nothing may change.
  task automatic gapCycles(input int n, input int expSel);
    for (int g = 0; g < n; g++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'b0, 1'b1);
      checkAll("gap", '0, expSel, expLocked, 1'b0);
    end
  endtask

  // Transmit one slot for channel ch, MSB first, optionally marking bit 0 with frame_sync.
  task automatic sendSlot(input logic [DATA_W-1:0] data, input int ch, input logic withSync,
                          input logic earlySync, input int minGap, input int maxGap,
                          input logic badPar);
    logic [SLOT_W-1:0] slot;
    int nextCh;
`ifdef TDM_DEMUX_PARITY_EN
    slot = {data, (^data) ^ badPar};
`else
    slot = data;
`endif
    nextCh = (ch + 1) % NUM_CH;
    for (int i = 0; i < SLOT_W; i++) begin
      gapCycles(int'($urandom_range(maxGap, minGap)), (i == 0) ? ((ch == 0) ? 0 : ch) : ch);
      applyStimulus(slot[SLOT_W-1-i], (i == 0) && withSync, 1'b1, 1'b1);
      if (i == 0 && withSync) expLocked = 1'b1;
      if (i < SLOT_W - 1) begin
        checkAll($sformatf("ch%0d_bit%0d", ch, i), '0, ch, 1'b1, (i == 0) && earlySync);
`ifdef TDM_DEMUX_PARITY_EN
        checkParity($sformatf("ch%0d_bit%0d", ch, i), 1'b0);
`endif
      end else if (badPar) begin
        checkAll($sformatf("ch%0d_badpar", ch), '0, nextCh, 1'b1, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
        checkParity($sformatf("ch%0d_badpar", ch), 1'b1);
`endif
      end else begin
        expData[ch] = data;
        checkAll($sformatf("ch%0d_done", ch), NUM_CH'(1) << ch, nextCh, 1'b1, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
        checkParity($sformatf("ch%0d_done", ch), 1'b0);
`endif
      end
    end
  endtask

  task automatic sendFrame(input logic [NUM_CH*DATA_W-1:0] f, input int minGap, input int maxGap);
    for (int ch = 0; ch < NUM_CH; ch++)
      sendSlot(f[ch*DATA_W +: DATA_W], ch, ch == 0, 1'b0, minGap, maxGap, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < NUM_CH; k++) expData[k] = '0;
    bus.din = 1'b0;
    bus.frame_sync = 1'b0;
    bus.din_en = 1'b0;

    // Reset held two clocks with the line toggling and sync asserted.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkAll("reset", '0, 0, 1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    checkParity("reset", 1'b0);
`endif

    // Good frame, no gaps.
    sendFrame(32'h00FF3CA5, 0, 0);
    checkOutput("good_frame_word", 64'(bus.ch_data), 64'h00FF3CA5);

    // Same frame with a strobe gap before every bit, then random frames with random gaps.
    sendFrame(32'h00FF3CA5, 1, 1);
    checkOutput("gap_frame_word", 64'(bus.ch_data), 64'h00FF3CA5);
    for (int f = 0; f < 6; f++) sendFrame($urandom, 0, 2);
    sendFrame(32'h00FF3CA5, 0, 0);

    // Missing sync at the start of the next frame.
    applyStimulus(1'($urandom), 1'b0, 1'b1, 1'b1);
    expLocked = 1'b0;
    checkAll("missing_sync", '0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'($urandom), 1'b0, 1'b1, 1'b1);
      checkAll("idle_ignore", '0, 0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkAll("idle_sync_unstrobed", '0, 0, 1'b0, 1'b0);
    checkOutput("missing_sync_word", 64'(bus.ch_data), 64'h00FF3CA5);

    // Early sync at ch2 bit 3; the sync bit starts ch0 = 0x81.
    sendSlot(8'($urandom), 0, 1'b1, 1'b0, 0, 0, 1'b0);
    sendSlot(8'($urandom), 1, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'($urandom), 1'b0, 1'b1, 1'b1);
      checkAll("ch2_partial", '0, 2, 1'b1, 1'b0);
    end
    sendSlot(8'h81, 0, 1'b1, 1'b1, 0, 0, 1'b0);
    for (int ch = 1; ch < NUM_CH; ch++) sendSlot(8'($urandom), ch, 1'b0, 1'b0, 0, 1, 1'b0);

    // Reset in the middle of ch1 (at its bit 5).
    sendSlot(8'($urandom), 0, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'($urandom), 1'b0, 1'b1, 1'b1);
      checkAll("ch1_partial", '0, 1, 1'b1, 1'b0);
    end
    applyStimulus(1'($urandom), 1'($urandom), 1'b1, 1'b0);
    for (int k = 0; k < NUM_CH; k++) expData[k] = '0;
    expLocked = 1'b0;
    checkAll("reset_mid_slot", '0, 0, 1'b0, 1'b0);
    sendFrame($urandom, 0, 1);

`ifdef TDM_DEMUX_PARITY_EN
    // Bad parity on ch0 keeps lock and the old ch0 value; good parity then loads it.
    sendSlot(8'h07, 0, 1'b1, 1'b0, 0, 0, 1'b1);
    for (int ch = 1; ch < NUM_CH; ch++) sendSlot(8'($urandom), ch, 1'b0, 1'b0, 0, 0, 1'b0);
    sendSlot(8'h07, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    checkOutput("parity_ch0", 64'(bus.ch_data[DATA_W-1:0]), 64'h07);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
